// File: rtl/arb_pkg.sv
// Shared definitions for memory_bus_arbiter: FSM state encoding and bus-owner encoding.
package arb_pkg;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t ST_IDLE    = 2'd0;
   localparam arb_state_t ST_OWN_CPU = 2'd1;
   localparam arb_state_t ST_OWN_DMA = 2'd2;

   typedef logic [1:0] arb_owner_t;

   localparam arb_owner_t OWNER_NONE = 2'b00;
   localparam arb_owner_t OWNER_CPU  = 2'b01;
   localparam arb_owner_t OWNER_DMA  = 2'b10;

   function automatic arb_owner_t owner_of(input arb_state_t s);
      case (s)
         ST_OWN_CPU: owner_of = OWNER_CPU;
         ST_OWN_DMA: owner_of = OWNER_DMA;
         default:    owner_of = OWNER_NONE;
      endcase
   endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Up-counter with synchronous clear that holds at MAX; used for the arbiter's guard and statistics counters.
module arb_sat_counter
   import arb_pkg::*;
#(
   parameter int           W   = 4,
   parameter logic [W-1:0] MAX = {W{1'b1}}
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {W{1'b0}};
      end else if (en_i && (cnt_q != MAX)) begin
         cnt_d = cnt_q + W'(1'b1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/memory_bus_arbiter.sv
// Shares one synchronous memory port between a fixed-priority CPU and a DMA requester.
// Optional ARB_STATS_EN adds saturating per-requester beat counters (cpu_beats, dma_beats).
module memory_bus_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 8,
   parameter int MAX_BURST    = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   input  logic              dma_last,
   output logic              dma_gnt,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]       cpu_beats,
   output logic [15:0]       dma_beats
`endif
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int BW = $clog2(MAX_BURST + 1);

   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [SW-1:0] STARVE_PRE = SW'(STARVE_LIMIT - 1);
   localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

   arb_state_t        state_q;
   arb_state_t        state_d;
   arb_owner_t        owner_s;
   logic              cpu_ack_q;
   logic              dma_ack_q;
   logic [SW-1:0]     starve_cnt_q;
   logic [BW-1:0]     burst_cnt_q;
   logic              cpu_own_s;
   logic              dma_own_s;
   logic              cpu_beat_s;
   logic              dma_beat_s;
   logic              starve_hit_s;
   logic              burst_hit_s;
   logic              dma_exit_s;
   logic              dma_entry_s;

   assign owner_s    = owner_of(state_q);
   assign cpu_own_s  = (owner_s == OWNER_CPU);
   assign dma_own_s  = (owner_s == OWNER_DMA);
   assign cpu_beat_s = cpu_own_s & cpu_req;
   assign dma_beat_s = dma_own_s & dma_req;

   // starve_cnt saturates, so ">= LIMIT-1" means "reaches LIMIT on this beat"
   assign starve_hit_s = dma_req && (starve_cnt_q >= STARVE_PRE);
   assign burst_hit_s  = dma_beat_s && (burst_cnt_q == BURST_LAST);
   assign dma_exit_s   = dma_own_s && (!dma_req || (dma_beat_s && dma_last) || (burst_hit_s && cpu_req));
   assign dma_entry_s  = (state_d == ST_OWN_DMA) && !dma_own_s;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cpu_req && !(dma_req && (starve_cnt_q == STARVE_MAX))) begin
               state_d = ST_OWN_CPU;
            end else if (dma_req) begin
               state_d = ST_OWN_DMA;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_OWN_CPU: begin
            if (!cpu_req) begin
               state_d = dma_req ? ST_OWN_DMA : ST_IDLE;
            end else if (starve_hit_s) begin
               state_d = ST_OWN_DMA;
            end else begin
               state_d = ST_OWN_CPU;
            end
         end
         ST_OWN_DMA: begin
            if (dma_exit_s) begin
               state_d = cpu_req ? ST_OWN_CPU : ST_IDLE;
            end else begin
               state_d = ST_OWN_DMA;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         cpu_ack_q <= 1'b0;
         dma_ack_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cpu_ack_q <= cpu_beat_s;
         dma_ack_q <= dma_beat_s;
      end
   end

   arb_sat_counter #(.W(SW), .MAX(STARVE_MAX)) u_starve_cnt (
      .clk_i (Clk),
      .rst_i (Reset),
      .clr_i (dma_entry_s),
      .en_i  (cpu_beat_s & dma_req),
      .cnt_o (starve_cnt_q)
   );

   // A beat at the burst limit either hands over or wraps; both restart the count
   arb_sat_counter #(.W(BW), .MAX(BURST_LAST)) u_burst_cnt (
      .clk_i (Clk),
      .rst_i (Reset),
      .clr_i (dma_exit_s | burst_hit_s),
      .en_i  (dma_beat_s),
      .cnt_o (burst_cnt_q)
   );

   always_comb begin
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
      mem_we    = 1'b0;
      if (cpu_beat_s) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_we    = cpu_we;
      end else if (dma_beat_s) begin
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
         mem_we    = dma_we;
      end else begin
         mem_addr  = {ADDR_W{1'b0}};
         mem_wdata = {DATA_W{1'b0}};
         mem_we    = 1'b0;
      end
   end

   assign cpu_gnt   = cpu_own_s;
   assign dma_gnt   = dma_own_s;
   assign cpu_ack   = cpu_ack_q;
   assign dma_ack   = dma_ack_q;
   assign cpu_rdata = mem_rdata;
   assign dma_rdata = mem_rdata;

`ifdef ARB_STATS_EN
   arb_sat_counter #(.W(16), .MAX(16'hFFFF)) u_cpu_beats (
      .clk_i (Clk),
      .rst_i (Reset),
      .clr_i (1'b0),
      .en_i  (cpu_beat_s),
      .cnt_o (cpu_beats)
   );

   arb_sat_counter #(.W(16), .MAX(16'hFFFF)) u_dma_beats (
      .clk_i (Clk),
      .rst_i (Reset),
      .clr_i (1'b0),
      .en_i  (dma_beat_s),
      .cnt_o (dma_beats)
   );
`endif

endmodule
